// File: rtl/alarm_set_ctrl.sv
// Alarm-clock front panel: button-driven time/alarm set FSM plus an independent ring/snooze/stop handler.
// Latency: button edges act on the next clk edge; LD_time/LD_alarm/STOP_al are held for LOAD_HOLD cycles.
module alarm_set_ctrl #(
  parameter int LOAD_HOLD    = 12,
  parameter int SNOOZE_TICKS = 3000,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  input  logic       alarm_in,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [2:0] mode,
  output logic       buzz,
  output logic       snooze_active
);

  localparam int HW = $clog2(LOAD_HOLD + 1);
  localparam int TW = $clog2(SNOOZE_TICKS + 1);
  localparam int CW = $clog2(MAX_SNOOZE + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] T_HOUR   = 3'd1;
  localparam logic [2:0] T_MIN    = 3'd2;
  localparam logic [2:0] COMMIT_T = 3'd3;
  localparam logic [2:0] A_HOUR   = 3'd4;
  localparam logic [2:0] A_MIN    = 3'd5;
  localparam logic [2:0] COMMIT_A = 3'd6;

  localparam logic [1:0] QUIET   = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZE  = 2'd2;

  logic [2:0]    r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [4:0]    r_hour;
  logic [5:0]    r_minute;
  logic          r_al_on;
  logic [4:0]    r_btn_q;
  logic [1:0]    r_al_state;
  logic [CW-1:0] r_snz_cnt;
  logic [TW-1:0] r_snz_tmr;
  logic [HW-1:0] r_stop_cnt;

  logic [4:0] w_btn;
  logic [4:0] w_edge;
  logic       w_mode_e, w_inc_e, w_alarm_e, w_snooze_e, w_stop_e;
  logic       w_stop_req;
  logic       w_snz_ok;

  assign w_btn      = {btn_mode, btn_inc, btn_alarm, btn_snooze, btn_stop};
  assign w_edge     = w_btn & ~r_btn_q;
  assign w_mode_e   = w_edge[4];
  assign w_inc_e    = w_edge[3];
  assign w_alarm_e  = w_edge[2];
  assign w_snooze_e = w_edge[1];
  assign w_stop_e   = w_edge[0];

  // Switching the alarm off while it rings or snoozes behaves exactly like pressing stop.
  assign w_stop_req = w_stop_e | ~r_al_on;
  assign w_snz_ok   = w_snooze_e && (r_snz_cnt < CW'(MAX_SNOOZE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q <= '0;
    end else begin
      r_btn_q <= w_btn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_hour     <= '0;
      r_minute   <= '0;
      r_al_on    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mode_e)       r_state <= T_HOUR;
          else if (w_alarm_e) r_al_on <= ~r_al_on;
        end
        T_HOUR, A_HOUR: begin
          if (w_mode_e)     r_state <= (r_state == T_HOUR) ? T_MIN : A_MIN;
          else if (w_inc_e) r_hour  <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        end
        T_MIN, A_MIN: begin
          if (w_mode_e) begin
            r_state    <= (r_state == T_MIN) ? COMMIT_T : COMMIT_A;
            r_hold_cnt <= HW'(LOAD_HOLD - 1);
          end else if (w_inc_e) begin
            r_minute <= (r_minute == 6'd59) ? 6'd0 : r_minute + 6'd1;
          end
        end
        COMMIT_T, COMMIT_A: begin
          if (r_hold_cnt == '0) r_state    <= (r_state == COMMIT_T) ? A_HOUR : IDLE;
          else                  r_hold_cnt <= r_hold_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_al_state <= QUIET;
      r_snz_cnt  <= '0;
      r_snz_tmr  <= '0;
      r_stop_cnt <= '0;
    end else begin
      // A fresh stop request below overrides this decrement, restarting the hold.
      if (r_stop_cnt != '0) r_stop_cnt <= r_stop_cnt - 1'b1;
      case (r_al_state)
        QUIET: begin
          if (alarm_in && r_al_on && (r_stop_cnt == '0)) r_al_state <= RINGING;
        end
        RINGING: begin
          if (w_stop_req) begin
            r_al_state <= QUIET;
            r_snz_cnt  <= '0;
            r_snz_tmr  <= '0;
            r_stop_cnt <= HW'(LOAD_HOLD);
          end else if (w_snz_ok) begin
            r_al_state <= SNOOZE;
            r_snz_cnt  <= r_snz_cnt + 1'b1;
            r_snz_tmr  <= TW'(SNOOZE_TICKS);
            r_stop_cnt <= HW'(LOAD_HOLD);
          end
        end
        SNOOZE: begin
          if (w_stop_req) begin
            r_al_state <= QUIET;
            r_snz_cnt  <= '0;
            r_snz_tmr  <= '0;
            r_stop_cnt <= HW'(LOAD_HOLD);
          end else if (r_snz_tmr <= TW'(1)) begin
            r_snz_tmr  <= '0;
            r_al_state <= RINGING;
          end else begin
            r_snz_tmr <= r_snz_tmr - 1'b1;
          end
        end
        default: r_al_state <= QUIET;
      endcase
    end
  end

  assign H_in1         = 2'(r_hour / 5'd10);
  assign H_in0         = 4'(r_hour % 5'd10);
  assign M_in1         = 4'(r_minute / 6'd10);
  assign M_in0         = 4'(r_minute % 6'd10);
  assign mode          = r_state;
  assign LD_time       = (r_state == COMMIT_T);
  assign LD_alarm      = (r_state == COMMIT_A);
  assign STOP_al       = (r_stop_cnt != '0);
  assign AL_ON         = r_al_on;
  assign buzz          = (r_al_state == RINGING);
  assign snooze_active = (r_al_state == SNOOZE);

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: set sequence, digit wrap, commit pulses, snooze/stop handling, reset aborts.
module tb_alarm_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_alarm = 1'b0, btn_snooze = 1'b0, btn_stop = 1'b0;
  logic       alarm_in = 1'b0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, buzz, snooze_active;
  logic [2:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_set_ctrl dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alarm(btn_alarm),
    .btn_snooze(btn_snooze), .btn_stop(btn_stop), .alarm_in(alarm_in),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .mode(mode), .buzz(buzz), .snooze_active(snooze_active)
  );

  always #5 clk = ~clk;

  // bits: {mode, inc, alarm, snooze, stop}; returns on the negedge after the capturing posedge
  task automatic press(input logic [4:0] m);
    @(negedge clk);
    {btn_mode, btn_inc, btn_alarm, btn_snooze, btn_stop} = m;
    @(negedge clk);
    {btn_mode, btn_inc, btn_alarm, btn_snooze, btn_stop} = 5'b0;
  endtask

  task automatic press_n(input logic [4:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {btn_mode, btn_inc, btn_alarm, btn_snooze, btn_stop} = 5'b0;
    alarm_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON, mode, buzz, snooze_active} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
               {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON, mode, buzz, snooze_active});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_time_set();
    int cnt;
    press(5'b10000);
    n_checks++;
    if (mode !== 3'd1) begin n_fail++; $display("FAIL t_hour_mode got %0d want 1", mode); end
    press_n(5'b01000, 7);
    press(5'b10000);
    press_n(5'b01000, 30);
    press(5'b10000);
    n_checks++;
    if ({H_in1, H_in0, M_in1, M_in0} !== {2'd0, 4'd7, 4'd3, 4'd0}) begin
      n_fail++; $display("FAIL commit_t_digits got %0d%0d:%0d%0d want 07:30", H_in1, H_in0, M_in1, M_in0);
    end
    n_checks++;
    if (mode !== 3'd3 || LD_time !== 1'b1 || LD_alarm !== 1'b0) begin
      n_fail++; $display("FAIL commit_t_entry got mode=%0d ld_t=%b ld_a=%b want 3 1 0", mode, LD_time, LD_alarm);
    end
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (LD_time) cnt++; else break;
    end
    n_checks++;
    if (cnt !== 12) begin n_fail++; $display("FAIL ld_time_len got %0d want 12", cnt); end
    n_checks++;
    if (mode !== 3'd4) begin n_fail++; $display("FAIL after_commit_t_mode got %0d want 4", mode); end
  endtask

  // Continues in A_HOUR with hour=7, minute=30
  task automatic test_wrap_and_commit_a();
    int cnt;
    logic ld_t_seen;
    press_n(5'b01000, 16);
    n_checks++;
    if ({H_in1, H_in0} !== {2'd2, 4'd3}) begin n_fail++; $display("FAIL hour23 got %0d%0d want 23", H_in1, H_in0); end
    press(5'b01000);
    n_checks++;
    if ({H_in1, H_in0} !== 6'd0) begin n_fail++; $display("FAIL hour_wrap got %0d%0d want 00", H_in1, H_in0); end
    press(5'b10000);
    press_n(5'b01000, 29);
    n_checks++;
    if ({M_in1, M_in0} !== {4'd5, 4'd9}) begin n_fail++; $display("FAIL min59 got %0d%0d want 59", M_in1, M_in0); end
    press(5'b01000);
    n_checks++;
    if ({M_in1, M_in0} !== 8'd0) begin n_fail++; $display("FAIL min_wrap got %0d%0d want 00", M_in1, M_in0); end
    press(5'b10000);
    // mode and inc pressed while committing must be ignored
    btn_mode = 1'b1; btn_inc = 1'b1;
    cnt = LD_alarm ? 1 : 0;
    ld_t_seen = LD_time;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0;
      ld_t_seen |= LD_time;
      if (LD_alarm) cnt++; else break;
    end
    n_checks++;
    if (cnt !== 12 || ld_t_seen !== 1'b0) begin
      n_fail++; $display("FAIL ld_alarm_len got %0d ld_time_seen=%b want 12 0", cnt, ld_t_seen);
    end
    n_checks++;
    if (mode !== 3'd0 || {H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
      n_fail++; $display("FAIL after_commit_a got mode=%0d digits=%0d%0d:%0d%0d want 0 00:00", mode, H_in1, H_in0, M_in1, M_in0);
    end
  endtask

  task automatic test_mode_wins();
    do_reset();
    press(5'b10000);
    press(5'b11000);
    n_checks++;
    if (mode !== 3'd2 || {H_in1, H_in0} !== 6'd0) begin
      n_fail++; $display("FAIL mode_wins got mode=%0d hour=%0d%0d want 2 00", mode, H_in1, H_in0);
    end
  endtask

  // waits up to a bound for buzz; returns cycles after the snooze capture edge
  task automatic snooze_once(input string name);
    int k, scnt;
    press(5'b00010);
    n_checks++;
    if (buzz !== 1'b0 || snooze_active !== 1'b1 || STOP_al !== 1'b1) begin
      n_fail++; $display("FAIL %s_enter got buzz=%b snz=%b stop=%b want 0 1 1", name, buzz, snooze_active, STOP_al);
    end
    scnt = 1;
    k = 0;
    while (k < 3100) begin
      @(negedge clk);
      k++;
      if (STOP_al) scnt++;
      if (buzz) break;
    end
    n_checks++;
    if (k !== 3000 || scnt !== 12) begin
      n_fail++; $display("FAIL %s_timing got ring_after=%0d stop_len=%0d want 3000 12", name, k, scnt);
    end
  endtask

  task automatic test_alarm_snooze();
    do_reset();
    press(5'b00100);
    n_checks++;
    if (AL_ON !== 1'b1) begin n_fail++; $display("FAIL al_on got %b want 1", AL_ON); end
    @(negedge clk);
    alarm_in = 1'b1;
    @(negedge clk);
    alarm_in = 1'b0;
    n_checks++;
    if (buzz !== 1'b1) begin n_fail++; $display("FAIL ring got buzz=%b want 1", buzz); end
    snooze_once("snooze1");
    snooze_once("snooze2");
    snooze_once("snooze3");
    press(5'b00010);
    n_checks++;
    if (buzz !== 1'b1 || snooze_active !== 1'b0 || STOP_al !== 1'b0) begin
      n_fail++; $display("FAIL snooze4_ignored got buzz=%b snz=%b stop=%b want 1 0 0", buzz, snooze_active, STOP_al);
    end
    press(5'b00001);
    n_checks++;
    if (buzz !== 1'b0 || STOP_al !== 1'b1) begin
      n_fail++; $display("FAIL stop got buzz=%b stop=%b want 0 1", buzz, STOP_al);
    end
    // alarm still asserted: must stay quiet until STOP_al drops
    alarm_in = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (STOP_al !== 1'b0 || buzz !== 1'b0) begin
      n_fail++; $display("FAIL quiet_hold got stop=%b buzz=%b want 0 0", STOP_al, buzz);
    end
    @(negedge clk);
    alarm_in = 1'b0;
    n_checks++;
    if (buzz !== 1'b1) begin n_fail++; $display("FAIL reringe got buzz=%b want 1", buzz); end
    press(5'b00010);
    n_checks++;
    if (snooze_active !== 1'b1) begin n_fail++; $display("FAIL count_cleared got snz=%b want 1", snooze_active); end
    press(5'b00100);
    @(negedge clk);
    n_checks++;
    if (AL_ON !== 1'b0 || snooze_active !== 1'b0 || buzz !== 1'b0 || STOP_al !== 1'b1) begin
      n_fail++; $display("FAIL al_off_stop got al_on=%b snz=%b buzz=%b stop=%b want 0 0 0 1", AL_ON, snooze_active, buzz, STOP_al);
    end
  endtask

  task automatic test_stop_snooze_same();
    do_reset();
    press(5'b00100);
    @(negedge clk);
    alarm_in = 1'b1;
    @(negedge clk);
    alarm_in = 1'b0;
    press(5'b00011);
    n_checks++;
    if (buzz !== 1'b0 || snooze_active !== 1'b0 || STOP_al !== 1'b1) begin
      n_fail++; $display("FAIL stop_wins got buzz=%b snz=%b stop=%b want 0 0 1", buzz, snooze_active, STOP_al);
    end
  endtask

  task automatic test_reset_commit_a();
    logic seen;
    do_reset();
    press(5'b10000);
    press_n(5'b01000, 5);
    press(5'b10000);
    press(5'b10000);
    repeat (12) @(negedge clk);
    press(5'b10000);
    press(5'b10000);
    repeat (4) @(negedge clk);
    n_checks++;
    if (LD_alarm !== 1'b1 || mode !== 3'd6) begin
      n_fail++; $display("FAIL commit_a_cycle5 got ld_a=%b mode=%0d want 1 6", LD_alarm, mode);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (LD_alarm !== 1'b0 || mode !== 3'd0 || {H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
      n_fail++; $display("FAIL reset_abort got ld_a=%b mode=%0d digits=%0d%0d:%0d%0d want 0 0 00:00",
                         LD_alarm, mode, H_in1, H_in0, M_in1, M_in0);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= LD_alarm | LD_time | STOP_al;
    end
    n_checks++;
    if (seen !== 1'b0 || mode !== 3'd0) begin
      n_fail++; $display("FAIL no_pulse_after_reset got seen=%b mode=%0d want 0 0", seen, mode);
    end
  endtask

  initial begin
    test_reset();
    test_time_set();
    test_wrap_and_commit_a();
    test_mode_wins();
    test_alarm_snooze();
    test_stop_snooze_same();
    test_reset_commit_a();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_set_ctrl.md
ALARM_SET_CTRL -- requirements
Module: alarm_set_ctrl

Interface
REQ-001 SHALL have parameter LOAD_HOLD, default 12, clk cycles LD_time/LD_alarm/STOP_al are held (≥ one 1 s clock period + margin).
REQ-002 SHALL have parameter SNOOZE_TICKS, default 3000, clk cycles of snooze delay (5 min at 10 Hz).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 SHALL have port clk  in  1  10 Hz system clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports btn_mode, btn_inc, btn_alarm, btn_snooze, btn_stop  in  1 each  synchronous level buttons; actions occur on rising edge (0 in previous cycle, 1 now).
REQ-007 SHALL have port alarm_in  in  1  Alarm output of the clock block.
REQ-008 SHALL have ports H_in1 out 2, H_in0 out 4, M_in1 out 4, M_in0 out 4  BCD digits of the edited hour/minute.
REQ-009 SHALL have ports LD_time, LD_alarm, STOP_al, AL_ON  out  1 each  drive the clock block's same-named inputs.
REQ-010 SHALL have ports mode out 3 (FSM state code), buzz out 1 (audible alarm), snooze_active out 1.

Function
REQ-011 Set FSM states/codes SHALL be IDLE=0, T_HOUR=1, T_MIN=2, COMMIT_T=3, A_HOUR=4, A_MIN=5, COMMIT_A=6; mode output equals current code.
REQ-012 btn_mode edge SHALL advance IDLE->T_HOUR->T_MIN->COMMIT_T and A_HOUR->A_MIN->COMMIT_A; COMMIT_T exits to A_HOUR, COMMIT_A exits to IDLE, each after LOAD_HOLD cycles.
REQ-013 Edit registers hour (5 bit, 0-23) and minute (6 bit, 0-59) SHALL persist across states; btn_inc edge in T_HOUR/A_HOUR does hour=(hour+1) mod 24, in T_MIN/A_MIN minute=(minute+1) mod 60.
REQ-014 H_in1/H_in0/M_in1/M_in0 SHALL continuously equal the BCD split of hour and minute (23 -> 2,3; 59 -> 5,9).
REQ-015 LD_time SHALL be 1 exactly during the LOAD_HOLD cycles of COMMIT_T, LD_alarm exactly during COMMIT_A; never both.
REQ-016 btn_mode and btn_inc edges during COMMIT_T/COMMIT_A SHALL be ignored; simultaneous btn_mode and btn_inc edges: mode wins, inc discarded.
REQ-017 btn_alarm edge SHALL toggle AL_ON in IDLE only; ignored in other states.
REQ-018 Alarm handler SHALL be independent of the set FSM, states QUIET, RINGING, SNOOZE.
REQ-019 QUIET->RINGING when alarm_in=1 and AL_ON=1; buzz=1 in RINGING.
REQ-020 btn_snooze edge in RINGING with snooze count < MAX_SNOOZE SHALL start a LOAD_HOLD-cycle STOP_al pulse, increment count, load snooze timer with SNOOZE_TICKS, enter SNOOZE (buzz=0, snooze_active=1).
REQ-021 btn_snooze edge with count = MAX_SNOOZE SHALL be ignored (remain RINGING).
REQ-022 Snooze timer SHALL decrement each cycle in SNOOZE; at 0 re-enter RINGING (buzz=1) without requiring alarm_in.
REQ-023 btn_stop edge in RINGING or SNOOZE SHALL start a STOP_al pulse, clear count and timer, enter QUIET; buzz and snooze_active 0 on next cycle.
REQ-024 Simultaneous btn_stop and btn_snooze edges: stop wins.
REQ-025 AL_ON falling to 0 in RINGING/SNOOZE SHALL act as btn_stop.
REQ-026 New STOP_al request while one is active SHALL restart the hold count, not extend overlapping pulses.
REQ-027 QUIET SHALL not re-enter RINGING while STOP_al=1 (alarm_in still clearing).

Reset
REQ-028 reset=1 SHALL force immediately: set FSM IDLE, alarm handler QUIET, hour=0, minute=0, all H_in/M_in digits 0, LD_time=LD_alarm=STOP_al=AL_ON=buzz=snooze_active=0, mode=0, counters 0, edge-detect history 0.
REQ-029 Reset mid-COMMIT or mid-snooze SHALL abort with no further LD/STOP_al pulse after release.

Verification
REQ-030 Reset; btn_mode, 7x btn_inc, btn_mode, 30x btn_inc, btn_mode -> COMMIT_T, digits 0,7,3,0, LD_time=1 for exactly 12 cycles, then mode=4.
REQ-031 In T_HOUR from hour 23, btn_inc -> hour 0 (H_in1=0,H_in0=0); in T_MIN from 59, btn_inc -> 0.
REQ-032 IDLE btn_alarm -> AL_ON=1; alarm_in=1 -> buzz=1; btn_snooze -> STOP_al 12 cycles, buzz=0, snooze_active=1; 3000 cycles later buzz=1.
REQ-033 Fourth btn_snooze after three snoozes -> ignored, buzz stays 1; btn_stop -> buzz=0, STOP_al pulse, count cleared.
REQ-034 btn_stop and btn_snooze same cycle in RINGING -> QUIET, snooze_active=0.
REQ-035 Assert reset during COMMIT_A cycle 5 -> LD_alarm=0 immediately, mode=0, digits 0, no LD pulse after release.
